arbitro_rr_4a1: RTL and testbench
=================================

// Module: arbitro_rr_4a1
// PURPOSE
//  - 4-to-1 round-robin arbiter, the gather side of the 1-to-4 push arbiter.
//  - Pops words from four source FIFOs (first-word-fall-through) and pushes them into one destination FIFO.
//  - Gated by the global 4-bit one-hot state from the main control FSM; arbitrates only in ACTIVE.
//  - Respects per-source empty and destination almost_full.
// PARAMETERS
//  DATA_W  6  width of each data word
//  BURST   2  max consecutive grants to one source before rotating (>=1)
//  CNT_W   8  width of per-source grant counters (ARB_STATS_EN only)
// PORTS
//  clk           in   1       single clock, all logic on posedge
//  reset         in   1       synchronous, active-high
//  state         in   4       main FSM state, one-hot: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE
//  empty0..3     in   1 each  source FIFO i empty
//  data_in0..3   in   DATA_W  source FIFO i head word (FWFT, valid while !empty_i)
//  almost_full   in   1       destination FIFO almost full
//  pop0..3       out  1 each  pop source FIFO i (combinational, at most one high)
//  push          out  1       registered push to destination
//  data_out      out  DATA_W  registered word, valid when push=1
//  grant_cnt0..3 out  CNT_W   grants per source (ARB_STATS_EN only)
// BEHAVIOUR
//  - Clock and reset: one clock clk; reset is synchronous and active-high.
//  - Reset (reset=1 or state==RESET) at the next posedge:
//      push=0, data_out=0, ptr=3 (first search starts at source 0), burst_cnt=0, grant_cnt*=0.
//      pop0..3=0 combinationally while asserted.
//  - Eligibility: eligible = (state==ACTIVE) && !almost_full && !reset; req_i = !empty_i.
//  - Grant selection: if eligible and burst_cnt<BURST and req[ptr], grant stays on ptr.
//      Otherwise search ptr+1, ptr+2, ptr+3, ptr (mod 4); first requester wins.
//      No requester: no grant.
//  - Pop: pop_g = 1 in the same cycle as grant g.
//  - Latency 1: at the posedge ending a grant cycle, push<=1 and data_out<=data_in_g; otherwise push<=0.
//      data_out holds its last value when push=0.
//  - Pointer/burst update on a grant to g:
//      same source: burst_cnt++;
//      new source: ptr<=g, burst_cnt<=1.
//      Cycle with no grant: burst_cnt<=0, ptr held.
//  - Destination headroom: the destination almost_full threshold must leave >=1 free slot,
//      because one pushed word can be in flight after almost_full rises.
//  - Boundary conditions:
//      Source empties mid-burst: rotate to the next requester that cycle; no bubble.
//      All sources empty: idle, push=0.
//      almost_full rising: no pop that cycle; a word popped the previous cycle is still pushed.
//      state leaves ACTIVE mid-burst: pops stop immediately; the in-flight word is still pushed;
//        burst_cnt<=0; ptr held.
//      reset mid-operation: the in-flight word is dropped (push=0). Quiescing first is the control FSM's job.
//      BURST=1: pure round-robin.
// CONFIGURATION
//  - ARB_STATS_EN defined: grant_cnt0..3 ports exist.
//      grant_cnt_i increments on each pop_i and wraps at 2^CNT_W.
//      Cleared by reset or state==INIT.
//  - ARB_STATS_EN undefined: no counter ports, no counter logic. Arbitration behaviour is identical.
// STRUCTURE
//  - Shared include arbitro_defs.vh holds:
//      state encodings ST_RESET/ST_INIT/ST_IDLE/ST_ACTIVE;
//      default DATA_W.
//      The 1-to-4 arbiter and the main FSM use the same file.
//  - Sub-module rr_pick4 (combinational): inputs req[3:0], ptr[1:0], hold; outputs gnt[3:0] one-hot, gnt_idx[1:0].
//  - Top level holds ptr, burst_cnt, output registers and the optional counters.
// TESTING
//  1. All sources non-empty, almost_full=0, ACTIVE, BURST=2
//     -> pop order 0,0,1,1,2,2,3,3,0; push follows each pop by 1 cycle with matching data.
//  2. Only empty2=0, data_in2=6'h2A
//     -> pop2 every cycle; push=1 with data_out=6'h2A from the 2nd cycle on; no other pop.
//  3. Mid-stream almost_full=1 for 3 cycles
//     -> pops stop that cycle; exactly one more push; resume at the same ptr when almost_full=0.
//  4. state 1000->0100 during a source-1 burst
//     -> pop1 drops that cycle; last word pushed; back in ACTIVE, source 1 is re-granted with a fresh burst.
//  5. reset=1 for 1 cycle mid-traffic
//     -> next cycle push=0, data_out=0; first grant afterwards goes to source 0.
//  6. ARB_STATS_EN: 10 grants split 4/3/2/1 over sources 0..3
//     -> grant_cnt0..3 = 4,3,2,1; state=INIT clears all to 0.

Source files
------------

// File: rtl/arbitro_rr_4a1_pkg.sv
// Shared definitions for the arbitration slice: main-FSM state
// encodings (one-hot) and the default data width.
package arbitro_rr_4a1_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_e;

    localparam int DATA_W_DEF = 6;

endpackage

// File: rtl/arbitro_rr_4a1_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
// Ports: req[3:0], ptr[1:0], hold in; gnt[3:0] one-hot, gnt_idx[1:0] out.
// hold keeps the grant on ptr; otherwise search ptr+1..ptr+4 (mod 4).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       hold,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = hold;
        idx     = '0;
        if (hold) begin
            gnt[ptr] = 1'b1;
        end
        for (int k = 1; k < 5; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// arbitro_rr_4a1: 4-to-1 round-robin gather arbiter (FWFT sources -> one
// destination FIFO), arbitrating only in ACTIVE, with BURST-limited holds.
// Ports: clk, reset (sync, active-high), state[3:0] one-hot, empty0..3,
// data_in0..3, almost_full; pop0..3 (comb), push, data_out (registered).
// Optional ARB_STATS_EN adds grant_cnt0..3 (wrapping per-source pop counts).
module arbitro_rr_4a1
    import arbitro_rr_4a1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BURST  = 2
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty3,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              almost_full,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic              push,
    output logic [DATA_W-1:0] data_out
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  grant_cnt2,
    output logic [CNT_W-1:0]  grant_cnt3
`endif
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(BURST);

    logic [1:0]        ptr;
    logic [BW-1:0]     burst_cnt;
    // Set by reset so the first search starts at source 0
    // instead of holding on the parked pointer (3).
    logic              fresh;
    logic              rst;
    logic              eligible;
    logic [3:0]        req;
    logic              hold;
    logic [3:0]        gnt;
    logic [1:0]        gnt_idx;
    logic              any;
    logic [DATA_W-1:0] din_sel;

    assign rst      = reset || (state == ST_RESET);
    assign eligible = (state == ST_ACTIVE) && !almost_full && !reset;
    assign req      = eligible ? ~{empty3, empty2, empty1, empty0} : 4'b0;
    assign hold     = req[ptr] && !fresh && (burst_cnt < BMAX);
    assign any      = |gnt;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .hold   (hold),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    assign pop0 = gnt[0];
    assign pop1 = gnt[1];
    assign pop2 = gnt[2];
    assign pop3 = gnt[3];

    always_comb begin
        case (gnt_idx)
            2'd0:    din_sel = data_in0;
            2'd1:    din_sel = data_in1;
            2'd2:    din_sel = data_in2;
            default: din_sel = data_in3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push      <= 1'b0;
            data_out  <= '0;
            ptr       <= 2'd3;
            burst_cnt <= '0;
            fresh     <= 1'b1;
        end else if (any) begin
            push     <= 1'b1;
            data_out <= din_sel;
            fresh    <= 1'b0;
            if (!fresh && gnt_idx == ptr) begin
                // Sole requester re-won via search: saturate.
                if (burst_cnt != BMAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                ptr       <= gnt_idx;
                burst_cnt <= BW'(1);
            end
        end else begin
            push      <= 1'b0;
            burst_cnt <= '0;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt [4];

    always_ff @(posedge clk) begin
        if (rst || state == ST_INIT) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt0 = cnt[0];
    assign grant_cnt1 = cnt[1];
    assign grant_cnt2 = cnt[2];
    assign grant_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// Testbench for arbitro_rr_4a1: behavioural model plus directed scenarios.
module tb_arbitro_rr_4a1;
    import arbitro_rr_4a1_pkg::*;

    localparam int DW    = 6;
    localparam int BURST = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    state;
    logic [3:0]    empty;
    logic [DW-1:0] din [4];
    logic          af;
    logic          pop0, pop1, pop2, pop3, push;
    logic [DW-1:0] data_out;
`ifdef ARB_STATS_EN
    logic [7:0]    gc0, gc1, gc2, gc3;
`endif

    always #5 clk = ~clk;

    arbitro_rr_4a1 #(.DATA_W(DW), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .state(state),
        .empty0(empty[0]), .empty1(empty[1]),
        .empty2(empty[2]), .empty3(empty[3]),
        .data_in0(din[0]), .data_in1(din[1]),
        .data_in2(din[2]), .data_in3(din[3]),
        .almost_full(af),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .push(push), .data_out(data_out)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt0(gc0), .grant_cnt1(gc1),
        .grant_cnt2(gc2), .grant_cnt3(gc3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popidx();
        logic [3:0] p;
        p = {pop3, pop2, pop1, pop0};
        case (p)
            4'b0000: return -1;
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 9;
        endcase
    endfunction

    // Behavioural model: last granted source, length of current run,
    // whether we are just out of reset, and expected registered outputs.
    int          last = 3;
    int          run = 0;
    bit          fresh = 1;
    bit          m_push = 0;
    logic [DW-1:0] m_data = '0;
    int          m_cnt [4] = '{0, 0, 0, 0};
    int          g_exp = -1;
    bit          chk = 0;

    always @(negedge clk) begin
        int g;
        bit elig;
        int src;
        elig = (state == ST_ACTIVE) && !af && !reset;
        g = -1;
        if (elig) begin
            if (!fresh && run < BURST && !empty[last]) begin
                g = last;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    src = (last + k) % 4;
                    if (g < 0 && !empty[src]) g = src;
                end
            end
        end
        g_exp = g;
        if (chk) begin
            check("pops", {28'd0, pop3, pop2, pop1, pop0},
                  (g < 0) ? 32'd0 : (32'd1 << g));
            check("push", {31'd0, push}, {31'd0, m_push});
            check("data_out", {26'd0, data_out}, {26'd0, m_data});
`ifdef ARB_STATS_EN
            check("gc0", {24'd0, gc0}, m_cnt[0]);
            check("gc1", {24'd0, gc1}, m_cnt[1]);
            check("gc2", {24'd0, gc2}, m_cnt[2]);
            check("gc3", {24'd0, gc3}, m_cnt[3]);
`endif
        end
    end

    always @(posedge clk) begin
        if (reset || state == ST_RESET) begin
            m_push = 0;
            m_data = '0;
            last   = 3;
            run    = 0;
            fresh  = 1;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            chk    = 1;
        end else begin
            if (g_exp >= 0) begin
                m_push = 1;
                m_data = din[g_exp];
                if (!fresh && g_exp == last) begin
                    run = (run < BURST) ? run + 1 : BURST;
                end else begin
                    last = g_exp;
                    run  = 1;
                end
                fresh = 0;
                m_cnt[g_exp] = (m_cnt[g_exp] + 1) % 256;
            end else begin
                m_push = 0;
                run    = 0;
            end
            if (state == ST_INIT) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end
        end
    end

    bit vary = 1;
    int cyc = 0;

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
        if (vary) begin
            for (int i = 0; i < 4; i++) din[i] = DW'(i * 13 + cyc * 5);
        end
    endtask

    initial begin
        int exp1 [9];
        int got;
        int prev;
        int npush;
        bit seen;
`ifdef ARB_STATS_EN
        int srcs [10];
`endif
        exp1 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        reset = 1'b1;
        state = ST_RESET;
        empty = 4'hF;
        af    = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        adv();
        adv();
        @(negedge clk);
        check("rst_push", {31'd0, push}, 32'd0);
        check("rst_data", {26'd0, data_out}, 32'd0);

        // 1: all sources busy, BURST=2 order
        adv();
        reset = 1'b0;
        state = ST_ACTIVE;
        empty = 4'h0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            got = popidx();
            check("t1_order", got, exp1[i]);
            adv();
        end

        // 2: only source 2, fixed word
        empty  = 4'b1011;
        vary   = 0;
        din[2] = 6'h2A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_pop2", popidx(), 2);
            if (i >= 1) begin
                check("t2_push", {31'd0, push}, 32'd1);
                check("t2_data", {26'd0, data_out}, 32'h2A);
            end
            adv();
        end

        // 3: almost_full for 3 cycles
        empty = 4'h0;
        vary  = 1;
        prev  = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            prev = popidx();
            adv();
        end
        af    = 1'b1;
        npush = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_nopop", popidx(), -1);
            if (push) npush++;
            adv();
        end
        check("t3_onepush", npush, 1);
        af = 1'b0;
        @(negedge clk);
        check("t3_resume", popidx(), prev);
        adv();

        // 4: leave ACTIVE during a source-1 burst
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (popidx() == 1) seen = 1;
            adv();
        end
        check("t4_found_src1", {31'd0, seen}, 32'd1);
        state = ST_IDLE;
        @(negedge clk);
        check("t4_nopop", popidx(), -1);
        check("t4_lastpush", {31'd0, push}, 32'd1);
        adv();
        adv();
        state = ST_ACTIVE;
        @(negedge clk);
        check("t4_regrant_a", popidx(), 1);
        adv();
        @(negedge clk);
        check("t4_regrant_b", popidx(), 1);
        adv();
        @(negedge clk);
        check("t4_rotate", popidx(), 2);
        adv();

        // 5: one-cycle reset mid-traffic
        adv();
        reset = 1'b1;
        @(negedge clk);
        check("t5_nopop_rst", popidx(), -1);
        adv();
        reset = 1'b0;
        @(negedge clk);
        check("t5_push0", {31'd0, push}, 32'd0);
        check("t5_data0", {26'd0, data_out}, 32'd0);
        check("t5_first0", popidx(), 0);
        adv();

`ifdef ARB_STATS_EN
        // 6: grant counters 4/3/2/1, then INIT clears
        reset = 1'b1;
        adv();
        reset = 1'b0;
        srcs = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        for (int i = 0; i < 10; i++) begin
            empty = ~(4'b0001 << srcs[i]);
            @(negedge clk);
            check("t6_pop", popidx(), srcs[i]);
            adv();
        end
        empty = 4'hF;
        adv();
        @(negedge clk);
        check("t6_gc0", {24'd0, gc0}, 32'd4);
        check("t6_gc1", {24'd0, gc1}, 32'd3);
        check("t6_gc2", {24'd0, gc2}, 32'd2);
        check("t6_gc3", {24'd0, gc3}, 32'd1);
        adv();
        state = ST_INIT;
        adv();
        @(negedge clk);
        check("t6_clr", {gc3, gc2, gc1, gc0}, 32'd0);
`endif

        state = ST_IDLE;
        empty = 4'hF;
        adv();
        adv();
        adv();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
